// File: rtl/arb_mux_n.sv
// N-input arbitrated mux with a single-entry registered output and valid/ready
// handshakes; the select comes from an internal fixed-priority or round-robin arbiter.
module arb_mux_n #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int ARB_MODE   = 1,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_CH*DATA_WIDTH-1:0] IN_DATA,
  input  logic [NUM_CH-1:0]            IN_VALID,
  output logic [NUM_CH-1:0]            IN_READY,
  output logic [DATA_WIDTH-1:0]        OUT_DATA,
  output logic [CH_W-1:0]              OUT_CH,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [CH_W-1:0]       ptr_q, ptr_d;

  logic                  load_en;
  logic                  found;
  logic [CH_W-1:0]       gnt_idx;
  logic [NUM_CH-1:0]     grant;
  logic [DATA_WIDTH-1:0] sel_data;

  assign load_en = !valid_q || OUT_READY;

  // Search starts at the pointer in round-robin mode, at channel 0 otherwise.
  always_comb begin : arbiter
    int base;
    int cand;
    found   = 1'b0;
    gnt_idx = '0;
    base    = (ARB_MODE == 1) ? int'(ptr_q) : 0;
    cand    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = base + k;
      if (cand >= NUM_CH) begin
        cand = cand - NUM_CH;
      end
      if (!found && IN_VALID[CH_W'(cand)]) begin
        found   = 1'b1;
        gnt_idx = CH_W'(cand);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_grant
    assign grant[gi] = found && (gnt_idx == CH_W'(gi));
  end

  assign IN_READY = grant & {NUM_CH{load_en && RST}};

  // AND-OR select: only the granted channel's word can reach the register.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) begin
        sel_data = sel_data | IN_DATA[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      valid_d = found;
      if (found) begin
        data_d = sel_data;
        ch_d   = gnt_idx;
        if (ARB_MODE == 1) begin
          ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign OUT_VALID = valid_q;
  assign OUT_DATA  = data_q;
  assign OUT_CH    = ch_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: instance 0 runs fixed priority, instance 1 round robin,
// each against its own reference model and scoreboard.
module tb_arb_mux_n;

  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [N*W-1:0] in_data [2];
  logic [N-1:0]   in_valid[2];
  logic [N-1:0]   in_ready[2];
  logic [W-1:0]   out_data[2];
  logic [1:0]     out_ch  [2];
  logic           out_valid[2];
  logic           out_ready[2];
  logic [N-1:0]   acc     [2];

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  typedef struct packed {
    logic [1:0]   ch;
    logic [W-1:0] data;
  } exp_t;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    arb_mux_n #(
      .DATA_WIDTH(W),
      .NUM_CH    (N),
      .ARB_MODE  (gi)
    ) u_dut (
      .CLK      (clk),
      .RST      (rst_n),
      .IN_DATA  (in_data[gi]),
      .IN_VALID (in_valid[gi]),
      .IN_READY (in_ready[gi]),
      .OUT_DATA (out_data[gi]),
      .OUT_CH   (out_ch[gi]),
      .OUT_VALID(out_valid[gi]),
      .OUT_READY(out_ready[gi])
    );

    exp_t         q[$];
    exp_t         e;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;
    logic [1:0]   prev_ch    = '0;
    bit           drained    = 1'b0;

    // Monitor: pops one expected word each time the sink consumes the output.
    always @(negedge clk) begin
      if (prev_stall) begin
        chk(out_valid[gi] && out_data[gi] == prev_data && out_ch[gi] == prev_ch,
            $sformatf("stall_hold[%0d]", gi), {out_valid[gi], out_ch[gi], out_data[gi]},
            {1'b1, prev_ch, prev_data});
      end
      if (rst_n && out_valid[gi] && out_ready[gi]) begin
        if (q.size() == 0) begin
          chk(1'b0, $sformatf("unexpected_out[%0d]", gi), {out_ch[gi], out_data[gi]}, 64'd0);
        end else begin
          e = q.pop_front();
          chk(out_ch[gi] == e.ch && out_data[gi] == e.data, $sformatf("out_word[%0d]", gi),
              {out_ch[gi], out_data[gi]}, e);
        end
      end
      prev_stall = rst_n && out_valid[gi] && !out_ready[gi];
      prev_data  = out_data[gi];
      prev_ch    = out_ch[gi];
      if (done && !drained) begin
        drained = 1'b1;
        chk(q.size() == 0, $sformatf("drain[%0d]", gi), 64'(q.size()), 64'd0);
      end
    end

    // Reference model: output register occupancy and rotation pointer as plain integers.
    int           m_ptr   = 0;
    int           win;
    int           c;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    logic [1:0]   m_ch    = '0;
    logic [N-1:0] exp_ready;
    bit           load;

    always @(negedge clk) begin
      #1;
      exp_ready = '0;
      win       = -1;
      load      = !m_valid || out_ready[gi];
      if (rst_n && load) begin
        for (int k = 0; k < N; k++) begin
          c = ((gi == 1 ? m_ptr : 0) + k) % N;
          if (win < 0 && in_valid[gi][c[1:0]]) win = c;
        end
        if (win >= 0) exp_ready[win[1:0]] = 1'b1;
      end
      chk(in_ready[gi] == exp_ready, $sformatf("in_ready[%0d]", gi), 64'(in_ready[gi]), 64'(exp_ready));
      chk(out_valid[gi] == m_valid, $sformatf("out_valid[%0d]", gi), 64'(out_valid[gi]), 64'(m_valid));
      if (!m_valid) begin
        chk(out_data[gi] == m_data && out_ch[gi] == m_ch, $sformatf("idle_reg[%0d]", gi),
            {out_ch[gi], out_data[gi]}, {m_ch, m_data});
      end
      if (!rst_n) begin
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = '0;
        m_ptr   = 0;
        q.delete();
      end else if (load) begin
        if (win >= 0) begin
          m_valid = 1'b1;
          m_ch    = win[1:0];
          m_data  = in_data[gi][win*W +: W];
          q.push_back('{ch: m_ch, data: m_data});
          if (gi == 1) m_ptr = (win + 1) % N;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    acc[0] = in_valid[0] & in_ready[0];
    acc[1] = in_valid[1] & in_ready[1];
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int g, input int ch, input logic [W-1:0] val);
    in_data[g][ch*W +: W] = val;
  endtask

  // Producers hold an unaccepted request; otherwise they may raise a fresh one.
  task automatic rand_step(input int g);
    for (int i = 0; i < N; i++) begin
      if (!in_valid[g][i] || acc[g][i]) begin
        in_valid[g][i] = ($urandom_range(0, 99) < 60);
        set_word(g, i, $urandom);
      end
    end
    out_ready[g] = ($urandom_range(0, 99) < 70);
  endtask

  initial begin
    rst_n = 1'b0;
    acc[0] = '0;
    acc[1] = '0;
    for (int g = 0; g < 2; g++) begin
      in_valid[g]  = '1;
      out_ready[g] = 1'b1;
      for (int i = 0; i < N; i++) set_word(g, i, 32'hA0 + i + g * 16);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    // Fixed priority: ch1 and ch3 contend, then ch1 drops out.
    in_valid[0] = 4'b1010;
    repeat (7) cyc();
    in_valid[0] = 4'b1000;
    repeat (3) cyc();
    in_valid[0] = '0;

    // Backpressure on the round-robin instance.
    in_valid[1] = 4'b0100;
    set_word(1, 2, 32'h1234);
    cyc();
    out_ready[1] = 1'b0;
    in_valid[1]  = 4'b1011;
    repeat (5) cyc();
    out_ready[1] = 1'b1;
    repeat (2) cyc();

    // Idle, then pointer wrap.
    in_valid[1] = 4'b1000;
    cyc();
    in_valid[1] = '0;
    repeat (3) cyc();
    in_valid[1] = 4'b1001;
    repeat (2) cyc();
    in_valid[1] = '0;
    cyc();

    // Reset while a word is stalled in the output register.
    in_valid[1]  = 4'b0001;
    out_ready[1] = 1'b0;
    cyc();
    in_valid[1] = '0;
    repeat (2) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    out_ready[1] = 1'b1;
    repeat (3) cyc();

    repeat (3000) begin
      rand_step(0);
      rand_step(1);
      cyc();
    end

    for (int g = 0; g < 2; g++) begin
      in_valid[g]  = '0;
      out_ready[g] = 1'b1;
    end
    repeat (4) cyc();
    done = 1'b1;
    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
